flash_loader: RTL and testbench

// SPI-flash boot loader: the reading initiator for the serial flash responder. After reset it

---
 rtl/boot_pkg.sv | 23 ++
 rtl/spi_shifter.sv | 69 ++++++
 rtl/flash_loader.sv | 143 ++++++++++++++
 tb/tb_flash_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI-flash boot loader.
// Imported by the loader FSM and its SPI shift engine.
package boot_pkg;

    typedef enum logic [2:0] {
        Startup,
        SendCmd,
        ReadBits,
        WriteWord,
        WaitRamio,
        Done
    } boot_state_e;

    localparam logic [7:0] FlashCmdRead   = 8'h03;
    localparam logic [1:0] RamioWriteWord = 2'b11;
    localparam int unsigned SpiWordBits   = 32;

    // Serial bytes land first-byte-high; memory wants first byte low.
    function automatic logic [31:0] pack_le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// Bit-serial SPI mode-0 engine: 2 clk per bit, MSB first.
// Drives mosi while sclk is low, samples miso as sclk rises.
module spi_shifter
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [SpiWordBits-1:0] tx_word_i,
    input  logic [5:0]             bit_count_i,
    input  logic                   miso_i,
    output logic                   sclk_o,
    output logic                   mosi_o,
    output logic [SpiWordBits-1:0] rx_word_o,
    output logic                   done_o
);

    logic                   busy_q;
    logic                   sclk_q;
    logic                   mosi_q;
    logic                   done_q;
    logic [5:0]             cnt_q;
    logic [SpiWordBits-1:0] tx_q;
    logic [SpiWordBits-1:0] rx_q;

    // Low phase presents a bit, high phase captures one; idle keeps sclk low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= tx_word_i[SpiWordBits-1];
                    tx_q   <= {tx_word_i[SpiWordBits-2:0], 1'b0};
                    cnt_q  <= bit_count_i - 6'd1;
                end
            end else if (!sclk_q) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[SpiWordBits-2:0], miso_i};
            end else begin
                sclk_q <= 1'b0;
                if (cnt_q == 6'd0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    mosi_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q - 6'd1;
                    mosi_q <= tx_q[SpiWordBits-1];
                    tx_q   <= {tx_q[SpiWordBits-2:0], 1'b0};
                end
            end
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign rx_word_o = rx_q;
    assign done_o    = done_q;

endmodule

// File: rtl/flash_loader.sv
// Boot loader: one SPI READ, then copies the stream into RAM
// as little-endian words through the ramio request port.
module flash_loader
    import boot_pkg::*;
#(
    parameter int unsigned StartupWaitCycles      = 1_000_000,
    parameter int unsigned FlashTransferByteCount = 4096,
    parameter logic [23:0] FlashReadAddress       = 24'h0,
    parameter logic [31:0] RamStartAddress        = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        flash_clk,
    input  logic        flash_miso,
    output logic        flash_mosi,
    output logic        flash_cs_n,
    output logic        ramio_enable,
    output logic [1:0]  ramio_write_type,
    output logic [2:0]  ramio_read_type,
    output logic [31:0] ramio_address,
    output logic [31:0] ramio_data_in,
    input  logic        ramio_busy,
    output logic        done_o
);

    localparam int unsigned WaitW =
        (StartupWaitCycles > 0) ? $clog2(StartupWaitCycles + 1) : 1;
    localparam int unsigned CntW = $clog2(FlashTransferByteCount + 1);
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(StartupWaitCycles);
    localparam logic [CntW-1:0]  ByteTotal = CntW'(FlashTransferByteCount);
    localparam logic [CntW-1:0]  WordBytes = CntW'(4);

    boot_state_e       state_q;
    logic [WaitW-1:0]  wait_q;
    logic [CntW-1:0]   remain_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic              en_q;
    logic [1:0]        wtype_q;
    logic              cs_n_q;
    logic              done_q;
    logic              go_q;

    logic [31:0]       spi_tx;
    logic [31:0]       spi_rx;
    logic              spi_done;

    assign spi_tx = (state_q == SendCmd) ?
                    {FlashCmdRead, FlashReadAddress} : '0;

    spi_shifter u_spi (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (go_q),
        .tx_word_i   (spi_tx),
        .bit_count_i (6'(SpiWordBits)),
        .miso_i      (flash_miso),
        .sclk_o      (flash_clk),
        .mosi_o      (flash_mosi),
        .rx_word_o   (spi_rx),
        .done_o      (spi_done)
    );

    // Boot sequencer; cs_n stays low from the command until the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= Startup;
            wait_q   <= '0;
            remain_q <= ByteTotal;
            addr_q   <= RamStartAddress;
            data_q   <= '0;
            en_q     <= 1'b0;
            wtype_q  <= 2'b00;
            cs_n_q   <= 1'b1;
            done_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            unique case (state_q)
                Startup: begin
                    if (wait_q == WaitLast) begin
                        state_q <= SendCmd;
                        cs_n_q  <= 1'b0;
                        go_q    <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                SendCmd: begin
                    if (spi_done) begin
                        state_q <= ReadBits;
                        go_q    <= 1'b1;
                    end
                end
                ReadBits: begin
                    if (spi_done) begin
                        state_q <= WriteWord;
                    end
                end
                WriteWord: begin
                    if (!ramio_busy) begin
                        en_q    <= 1'b1;
                        wtype_q <= RamioWriteWord;
                        data_q  <= pack_le(spi_rx);
                        state_q <= WaitRamio;
                    end
                end
                WaitRamio: begin
                    // busy is ignored during the enable cycle itself
                    if (en_q) begin
                        en_q    <= 1'b0;
                        wtype_q <= 2'b00;
                    end else if (!ramio_busy) begin
                        addr_q   <= addr_q + 32'd4;
                        remain_q <= remain_q - WordBytes;
                        if (remain_q == WordBytes) begin
                            state_q <= Done;
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ReadBits;
                            go_q    <= 1'b1;
                        end
                    end
                end
                Done: begin
                    cs_n_q <= 1'b1;
                    done_q <= 1'b1;
                end
                default: state_q <= Startup;
            endcase
        end
    end

    assign flash_cs_n       = cs_n_q;
    assign ramio_enable     = en_q;
    assign ramio_write_type = wtype_q;
    assign ramio_read_type  = 3'b000;
    assign ramio_address    = addr_q;
    assign ramio_data_in    = data_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: behavioural SPI flash, randomised
// ramio backpressure, and a per-cycle scoreboard on the writes.
`timescale 1ns/1ps
module tb_flash_loader;

    localparam int NBYTES = 16;
    localparam int NWORDS = NBYTES / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flash_clk, flash_miso, flash_mosi, flash_cs_n;
    logic        ramio_enable, ramio_busy, done_o;
    logic [1:0]  ramio_write_type;
    logic [2:0]  ramio_read_type;
    logic [31:0] ramio_address, ramio_data_in;

    logic        sclk2, mosi2, cs2, en2, done2;
    logic        miso2 = 1'b0;
    logic        busy2 = 1'b0;
    logic [1:0]  wt2;
    logic [2:0]  rt2;
    logic [31:0] addr2, data2;

    flash_loader #(
        .StartupWaitCycles      (0),
        .FlashTransferByteCount (NBYTES),
        .FlashReadAddress       (24'h0),
        .RamStartAddress        (32'h0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flash_clk        (flash_clk),
        .flash_miso       (flash_miso),
        .flash_mosi       (flash_mosi),
        .flash_cs_n       (flash_cs_n),
        .ramio_enable     (ramio_enable),
        .ramio_write_type (ramio_write_type),
        .ramio_read_type  (ramio_read_type),
        .ramio_address    (ramio_address),
        .ramio_data_in    (ramio_data_in),
        .ramio_busy       (ramio_busy),
        .done_o           (done_o)
    );

    flash_loader #(
        .StartupWaitCycles      (10),
        .FlashTransferByteCount (4),
        .FlashReadAddress       (24'h0),
        .RamStartAddress        (32'h0)
    ) dut2 (
        .clk              (clk),
        .rst_n            (rst_n),
        .flash_clk        (sclk2),
        .flash_miso       (miso2),
        .flash_mosi       (mosi2),
        .flash_cs_n       (cs2),
        .ramio_enable     (en2),
        .ramio_write_type (wt2),
        .ramio_read_type  (rt2),
        .ramio_address    (addr2),
        .ramio_data_in    (data2),
        .ramio_busy       (busy2),
        .done_o           (done2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash contents and SPI responder
    logic [7:0]  fmem [0:NBYTES-1];
    int          bitcnt = 0;
    int          cmd_cnt = 0;
    int          fidx;
    logic [31:0] cmd_sr = '0;
    logic [31:0] cmd_last = '0;

    function automatic int bits_out();
        return (bitcnt > 32) ? bitcnt - 32 : 0;
    endfunction

    function automatic logic [31:0] exp_word(input int n);
        return {fmem[4*n+3], fmem[4*n+2], fmem[4*n+1], fmem[4*n]};
    endfunction

    // Count rising SPI edges; the first 32 are the command.
    always @(posedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n) begin
            bitcnt = 0;
        end else begin
            if (bitcnt < 32) cmd_sr = {cmd_sr[30:0], flash_mosi};
            bitcnt++;
            if (bitcnt == 32) begin
                cmd_last = cmd_sr;
                cmd_cnt++;
            end
        end
    end

    // Drive the next data bit after each falling SPI edge.
    always @(negedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n) begin
            flash_miso = 1'b0;
        end else if (bitcnt >= 32) begin
            fidx = bitcnt - 32;
            flash_miso = fmem[(fidx / 8) % NBYTES][7 - (fidx % 8)];
        end
    end

    // ramio responder: random busy, busy after writes, one long stall
    int   wr_cnt = 0;
    logic hold = 1'b0;
    int   hold_cnt = 0;
    bit   hold_used = 1'b0;
    int   busy_rem = 0;
    logic busy_seen = 1'b0;

    initial begin
        ramio_busy = 1'b0;
        forever begin
            @(posedge clk);
            busy_seen = ramio_busy;
            #1;
            if (ramio_enable) busy_rem = $urandom_range(0, 4);
            if (hold) begin
                hold_cnt++;
                if (hold_cnt == 50) begin
                    hold = 1'b0;
                    ramio_busy = 1'b0;
                end
            end else if (!hold_used && rst_n && wr_cnt == 1 &&
                         bits_out() == 64) begin
                hold = 1'b1;
                hold_used = 1'b1;
                hold_cnt = 0;
                ramio_busy = 1'b1;
            end else begin
                if (busy_rem > 0) busy_rem--;
                ramio_busy = (busy_rem > 0) || ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Scoreboard
    logic [31:0] ram [0:NWORDS-1];
    logic [31:0] last_data = '0;
    logic [31:0] first_addr = '1;
    logic [31:0] first_data = '0;
    bit          first_seen = 1'b0;
    bit          have_data = 1'b0;
    logic        prev_en = 1'b0;
    int          cmd_seen = 0;
    int          en2_cnt = 0;

    always @(negedge clk) if (rst_n && en2) en2_cnt++;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_cnt = 0;
                prev_en = 1'b0;
                have_data = 1'b0;
            end else begin
                chk("read_type", 32'(ramio_read_type), 32'd0);
                chk("bit_bound", 32'(bits_out() <= 32 * (wr_cnt + 1)), 32'd1);
                if (cmd_cnt != cmd_seen) begin
                    chk("command", cmd_last, 32'h0300_0000);
                    cmd_seen = cmd_cnt;
                end
                if (ramio_enable) begin
                    chk("single_enable", 32'(prev_en), 32'd0);
                    chk("enable_while_busy", 32'(busy_seen), 32'd0);
                    chk("write_type", 32'(ramio_write_type), 32'd3);
                    chk("address", ramio_address, 32'(4 * wr_cnt));
                    chk("word_fully_read", 32'(bits_out()),
                        32'(32 * (wr_cnt + 1)));
                    if (wr_cnt < NWORDS) begin
                        chk("data", ramio_data_in, exp_word(wr_cnt));
                        ram[wr_cnt] = ramio_data_in;
                    end else begin
                        chk("extra_write", 32'(wr_cnt), 32'(NWORDS - 1));
                    end
                    if (!first_seen) begin
                        first_addr = ramio_address;
                        first_data = ramio_data_in;
                        first_seen = 1'b1;
                    end
                    last_data = ramio_data_in;
                    have_data = 1'b1;
                    wr_cnt++;
                end else begin
                    chk("idle_write_type", 32'(ramio_write_type), 32'd0);
                    if (have_data) chk("data_hold", ramio_data_in, last_data);
                end
                if (hold && hold_cnt >= 2) begin
                    chk("stall_enable", 32'(ramio_enable), 32'd0);
                    chk("stall_sclk", 32'(flash_clk), 32'd0);
                end
                if (done_o) begin
                    chk("done_words", 32'(wr_cnt), 32'(NWORDS));
                    chk("done_cs_n", 32'(flash_cs_n), 32'd1);
                    chk("done_sclk", 32'(flash_clk), 32'd0);
                end
                prev_en = ramio_enable;
            end
        end
    end

    int n2;

    initial begin : main
        fmem[0] = 8'h37;
        fmem[1] = 8'h01;
        fmem[2] = 8'h01;
        fmem[3] = 8'h00;
        for (int i = 4; i < NBYTES; i++) fmem[i] = 8'($urandom);
        for (int i = 0; i < NWORDS; i++) ram[i] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(flash_cs_n), 32'd1);
        chk("rst_sclk", 32'(flash_clk), 32'd0);
        chk("rst_mosi", 32'(flash_mosi), 32'd0);
        chk("rst_enable", 32'(ramio_enable), 32'd0);
        chk("rst_write_type", 32'(ramio_write_type), 32'd0);
        chk("rst_address", ramio_address, 32'd0);
        chk("rst_data", ramio_data_in, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);

        rst_n = 1'b1;
        n2 = 0;
        @(negedge clk);
        chk("cs_n_first_cycle", 32'(flash_cs_n), 32'd0);
        if (cs2) n2++;
        for (int i = 0; i < 40 && cs2; i++) begin
            @(negedge clk);
            if (cs2) n2++;
        end
        chk("startup_wait_cycles", 32'(n2), 32'd10);

        for (int i = 0; i < 5000 && !done_o; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("done_reached", 32'(done_o), 32'd1);
        chk("write_count", 32'(wr_cnt), 32'(NWORDS));
        chk("first_addr", first_addr, 32'd0);
        chk("first_data", first_data, 32'h0001_0137);
        chk("stall_happened", 32'(hold_used), 32'd1);
        for (int i = 0; i < NWORDS; i++) chk("ram_word", ram[i], exp_word(i));
        chk("cmd_count", 32'(cmd_cnt), 32'd1);
        chk("dut2_done", 32'(done2), 32'd1);
        chk("dut2_writes", 32'(en2_cnt), 32'd1);

        for (int i = 0; i < NBYTES; i++) fmem[i] = 8'($urandom);
        for (int i = 0; i < NWORDS; i++) ram[i] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5000 && !(wr_cnt == 2 && bits_out() >= 80); i++)
            @(negedge clk);
        chk("reached_third_word", 32'(wr_cnt == 2 && bits_out() >= 80), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(flash_cs_n), 32'd1);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_sclk", 32'(flash_clk), 32'd0);
        chk("abort_address", ramio_address, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_cs_n", 32'(flash_cs_n), 32'd0);

        for (int i = 0; i < 5000 && !done_o; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("done2_reached", 32'(done_o), 32'd1);
        chk("write_count2", 32'(wr_cnt), 32'(NWORDS));
        for (int i = 0; i < NWORDS; i++) chk("ram_word2", ram[i], exp_word(i));
        chk("cmd_count2", 32'(cmd_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
